// File: rtl/apollo_spi_responder.sv
// apollo_spi_responder
// Responder end of the Apollo filter/tuner SPI link, used as an on-FPGA
// Apollo emulator and as the loopback target for link bring-up.
// Each frame is five octets. ss goes high between octets. Every octet is
// echoed back one octet later. Octets 0..3 form a 32-bit command, which is
// executed one clock after the fifth octet.
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   apollo_reset_n       host reset of the emulated uC (active low)
//   ss, sck, mosi        SPI from host (asynchronous, synchronised here)
//   miso                 SPI to host, inverted
//   status               ready / status-changed flag
//   tune_done            one-clock pulse from tuner logic
//   freq_word            last SET_FREQ frequency field
//   filter_en            filter enable from SET_FREQ
//   tuner_en             tuner enable from SET_FREQ
//   freq_valid           one-clock pulse when SET_FREQ is applied
//   pa_bias              PTT / PA bias enable
//   tuning               tuning cycle active
module apollo_spi_responder #(
    parameter int         CLOCK_HZ    = 1000000,
    parameter int         GAP_TIMEOUT = 4095,
    parameter int         READY_DELAY = 64,
    parameter logic [7:0] VERSION     = 8'h01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        apollo_reset_n,
    input  logic        ss,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        status,
    input  logic        tune_done,
    output logic [21:0] freq_word,
    output logic        filter_en,
    output logic        tuner_en,
    output logic        freq_valid,
    output logic        pa_bias,
    output logic        tuning
);

    localparam int TICK_MAX = CLOCK_HZ / 1000 - 1;
    localparam int PRE_W    = $clog2(CLOCK_HZ / 1000 + 1);
    localparam int GAP_W    = $clog2(GAP_TIMEOUT + 1);
    localparam int READY_W  = $clog2(READY_DELAY + 1);

    typedef enum logic [2:0] {
        FR_OCT0, FR_OCT1, FR_OCT2, FR_OCT3, FR_OCT4
    } frameState_t;

    logic [1:0]   r_ssSync, r_sckSync, r_mosiSync;
    logic         r_ssPrev, r_sckPrev;
    logic [7:0]   r_rxByte, r_txShift, r_lastRx;
    logic [3:0]   r_bitCnt;
    logic         r_miso, r_exec;
    frameState_t  r_frame;
    logic [31:0]  r_cmd;
    logic [GAP_W-1:0]   r_gapCnt;
    logic [PRE_W-1:0]   r_preCnt;
    logic [READY_W-1:0] r_readyCnt;
    logic [23:0]  r_pttTimer;
    logic [21:0]  r_freqWord;
    logic         r_status, r_filterEn, r_tunerEn, r_freqValid;
    logic         r_paBias, r_tuning, r_verPending;

    logic        w_rst, w_ssFall, w_ssRise, w_sckRise, w_sckFall;
    logic        w_tick, w_wdExpire, w_readySet, w_tuneDoneSet, w_statusSet;
    logic [7:0]  w_op, w_txByte;

    assign w_rst     = reset | ~apollo_reset_n;
    assign w_ssFall  = r_ssPrev & ~r_ssSync[1];
    assign w_ssRise  = ~r_ssPrev & r_ssSync[1];
    assign w_sckRise = ~r_sckPrev & r_sckSync[1] & ~r_ssSync[1];
    assign w_sckFall = r_sckPrev & ~r_sckSync[1] & ~r_ssSync[1];

    // Octet 0 carries the status byte, or the version byte once after
    // GET_VERSION. Later octets echo the previous received octet.
    assign w_txByte = (r_frame == FR_OCT0)
                      ? (r_verPending ? VERSION : {7'd0, r_status})
                      : r_lastRx;

    assign w_op          = r_cmd[31:24];
    assign w_tick        = (r_preCnt == PRE_W'(TICK_MAX));
    assign w_wdExpire    = w_tick & (r_pttTimer == 24'd1) & r_paBias
                           & ~(r_exec & ((w_op == 8'd2) | (w_op == 8'd3)));
    assign w_readySet    = (r_readyCnt == READY_W'(READY_DELAY - 1));
    // If an abort executes in the same clock as tune_done, the abort wins.
    assign w_tuneDoneSet = tune_done & r_tuning & ~(r_exec & (w_op == 8'd5));
    assign w_statusSet   = w_readySet | w_tuneDoneSet | w_wdExpire;

    assign miso       = r_miso;
    assign status     = r_status;
    assign freq_word  = r_freqWord;
    assign filter_en  = r_filterEn;
    assign tuner_en   = r_tunerEn;
    assign freq_valid = r_freqValid;
    assign pa_bias    = r_paBias;
    assign tuning     = r_tuning;

    // Two-flop synchronisers for the SPI pins, plus previous-value flops
    // used for edge detection.
    always_ff @(posedge clock) begin
        if (w_rst) begin
            r_ssSync   <= 2'b11;
            r_sckSync  <= 2'b00;
            r_mosiSync <= 2'b00;
            r_ssPrev   <= 1'b1;
            r_sckPrev  <= 1'b0;
        end else begin
            r_ssSync   <= {r_ssSync[0], ss};
            r_sckSync  <= {r_sckSync[0], sck};
            r_mosiSync <= {r_mosiSync[0], mosi};
            r_ssPrev   <= r_ssSync[1];
            r_sckPrev  <= r_sckSync[1];
        end
    end

    // This block handles bit shifting, octet framing and the frame-gap timeout.
    // The bit count saturates at 9, so an over-long octet is treated like a
    // runt instead of wrapping back to a valid count.
    always_ff @(posedge clock) begin
        if (w_rst) begin
            r_rxByte  <= 8'd0;
            r_txShift <= 8'd0;
            r_lastRx  <= 8'd0;
            r_bitCnt  <= 4'd0;
            r_miso    <= 1'b1;
            r_exec    <= 1'b0;
            r_frame   <= FR_OCT0;
            r_cmd     <= 32'd0;
            r_gapCnt  <= '0;
        end else begin
            r_exec <= 1'b0;
            if (w_ssFall) begin
                r_txShift <= {w_txByte[6:0], 1'b0};
                r_miso    <= ~w_txByte[7];
            end else if (w_sckFall) begin
                r_txShift <= {r_txShift[6:0], 1'b0};
                r_miso    <= ~r_txShift[7];
            end
            if (w_sckRise) begin
                r_rxByte <= {r_rxByte[6:0], r_mosiSync[1]};
                if (r_bitCnt != 4'd9) r_bitCnt <= r_bitCnt + 4'd1;
            end
            if (w_ssRise) begin
                r_bitCnt <= 4'd0;
                r_miso   <= 1'b1;
                if (r_bitCnt == 4'd8) begin
                    r_lastRx <= r_rxByte;
                    if (r_frame == FR_OCT4) begin
                        r_frame <= FR_OCT0;
                        r_exec  <= 1'b1;
                    end else begin
                        r_cmd   <= {r_cmd[23:0], r_rxByte};
                        r_frame <= frameState_t'(r_frame + 3'd1);
                    end
                end else if (r_bitCnt != 4'd0) begin
                    r_frame <= FR_OCT0;
                end
            end
            if (r_ssSync[1] && (r_frame != FR_OCT0)) begin
                if (r_gapCnt == GAP_W'(GAP_TIMEOUT - 1)) begin
                    r_frame  <= FR_OCT0;
                    r_gapCnt <= '0;
                end else begin
                    r_gapCnt <= r_gapCnt + 1'b1;
                end
            end else begin
                r_gapCnt <= '0;
            end
        end
    end

    // This block handles command execution, the PTT watchdog, the ready delay
    // and status. When a set event and GET_STATUS happen in the same clock,
    // the set event wins.
    always_ff @(posedge clock) begin
        if (w_rst) begin
            r_preCnt     <= '0;
            r_readyCnt   <= '0;
            r_pttTimer   <= 24'd0;
            r_freqWord   <= 22'd0;
            r_status     <= 1'b0;
            r_filterEn   <= 1'b0;
            r_tunerEn    <= 1'b0;
            r_freqValid  <= 1'b0;
            r_paBias     <= 1'b0;
            r_tuning     <= 1'b0;
            r_verPending <= 1'b0;
        end else begin
            r_freqValid <= 1'b0;
            r_preCnt    <= w_tick ? '0 : r_preCnt + 1'b1;
            if (r_readyCnt != READY_W'(READY_DELAY)) r_readyCnt <= r_readyCnt + 1'b1;
            if (w_tick && (r_pttTimer != 24'd0)) r_pttTimer <= r_pttTimer - 24'd1;
            if (w_wdExpire) r_paBias <= 1'b0;
            if (w_tuneDoneSet) r_tuning <= 1'b0;
            if (w_ssFall && (r_frame == FR_OCT0)) r_verPending <= 1'b0;
            if (r_exec) begin
                case (w_op)
                    8'd1: begin
                        r_filterEn  <= r_cmd[23];
                        r_tunerEn   <= r_cmd[22];
                        r_freqWord  <= r_cmd[21:0];
                        r_freqValid <= 1'b1;
                    end
                    8'd2: begin
                        r_paBias   <= 1'b1;
                        r_pttTimer <= (r_cmd[23:0] == 24'd0) ? 24'd1 : r_cmd[23:0];
                    end
                    8'd3: begin
                        r_paBias   <= 1'b0;
                        r_pttTimer <= 24'd0;
                    end
                    8'd4: if (r_tunerEn) r_tuning <= 1'b1;
                    8'd5: r_tuning <= 1'b0;
                    8'd7: r_verPending <= 1'b1;
                    default: ;
                endcase
            end
            if (w_statusSet) r_status <= 1'b1;
            else if (r_exec && (w_op == 8'd6)) r_status <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apollo_spi_responder.sv
// tb_apollo_spi_responder
// Self-checking bench for apollo_spi_responder. It plays the SPI host and
// compares each received frame against an expected-result queue.
module tb_apollo_spi_responder;

    localparam int CLK_HZ     = 20000;
    localparam int CLK_PER_MS = CLK_HZ / 1000;
    localparam int GAP        = 200;
    localparam int RDY        = 64;
    localparam int HALF       = 6;
    localparam int OCTGAP     = 10;

    logic        clock = 1'b0;
    logic        reset, apollo_reset_n, ss, sck, mosi, tune_done;
    logic        miso, status, filter_en, tuner_en, freq_valid, pa_bias, tuning;
    logic [21:0] freq_word;

    int testsRun = 0;
    int testsFailed = 0;
    int fvPulses = 0;
    int paLowCycles = 0;
    bit watchPa = 1'b0;

    logic [39:0] expQ[$];
    logic [39:0] rxQ[$];

    apollo_spi_responder #(
        .CLOCK_HZ(CLK_HZ), .GAP_TIMEOUT(GAP), .READY_DELAY(RDY), .VERSION(8'h01)
    ) dut (
        .clock(clock), .reset(reset), .apollo_reset_n(apollo_reset_n),
        .ss(ss), .sck(sck), .mosi(mosi), .miso(miso), .status(status),
        .tune_done(tune_done), .freq_word(freq_word), .filter_en(filter_en),
        .tuner_en(tuner_en), .freq_valid(freq_valid), .pa_bias(pa_bias),
        .tuning(tuning)
    );

    always #5 clock = ~clock;

    // Count freq_valid pulses, and count any drop of pa_bias while watched.
    always @(negedge clock) begin
        if (freq_valid) fvPulses++;
        if (watchPa && !pa_bias) paLowCycles++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic sendOctet(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        repeat (OCTGAP) @(negedge clock);
        ss = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clock);
            sck = 1'b1;
            rx  = {rx[6:0], ~miso};
            repeat (HALF) @(negedge clock);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clock);
        ss = 1'b1;
    endtask

    task automatic sendFrame(input logic [31:0] cmd);
        logic [7:0] first, b;
        logic [31:0] echo;
        sendOctet(cmd[31:24], 8, first);
        sendOctet(cmd[23:16], 8, b); echo[31:24] = b;
        sendOctet(cmd[15:8], 8, b);  echo[23:16] = b;
        sendOctet(cmd[7:0], 8, b);   echo[15:8]  = b;
        sendOctet(8'h00, 8, b);      echo[7:0]   = b;
        rxQ.push_back({first, echo});
        repeat (6) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; apollo_reset_n = 1'b1; ss = 1'b1; sck = 1'b0;
        mosi = 1'b0; tune_done = 1'b0;
        repeat (4) @(negedge clock);
        testsRun++;
        if ({status, pa_bias, tuning, filter_en, tuner_en, freq_valid, freq_word} !== 28'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {status, pa_bias, tuning, filter_en, tuner_en, freq_valid, freq_word});
        end
        testsRun++;
        if (miso !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL reset_miso: got %b expected 1", miso);
        end
        reset = 1'b0;
        repeat (RDY - 1) @(negedge clock);
        testsRun++;
        if (status !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL ready_early: got %b expected 0", status);
        end
        @(negedge clock);
        testsRun++;
        if (status !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ready_assert: got %b expected 1", status);
        end
        testsRun++;
        if (miso !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL idle_miso: got %b expected 1", miso);
        end
    endtask

    task automatic test_set_freq();
        int fv0;
        logic [39:0] exp, got;
        fv0 = fvPulses;
        expQ.push_back({8'h01, 32'h01C12345});
        sendFrame(32'h01C12345);
        testsRun++;
        if ({filter_en, tuner_en, freq_word} !== {1'b1, 1'b1, 22'h012345}) begin
            testsFailed++;
            $display("[TB] FAIL set_freq_fields: got %h expected %h",
                     {filter_en, tuner_en, freq_word}, {1'b1, 1'b1, 22'h012345});
        end
        testsRun++;
        if (fvPulses - fv0 != 1) begin
            testsFailed++; $display("[TB] FAIL freq_valid_pulses: got %0d expected 1", fvPulses - fv0);
        end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (rxQ.size() > 0) ? rxQ.pop_front() : 'x;
            testsRun++;
            if (got !== exp) begin
                testsFailed++; $display("[TB] FAIL set_freq_echo: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_ptt_watchdog();
        int n;
        logic [39:0] exp, got;
        expQ.push_back({8'h01, 32'h02000002});
        sendFrame(32'h02000002);
        n = 6;
        testsRun++;
        if (pa_bias !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ptt_enable: got %b expected 1", pa_bias);
        end
        while (pa_bias === 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        testsRun++;
        if (n < CLK_PER_MS || n > 3 * CLK_PER_MS + 8) begin
            testsFailed++;
            $display("[TB] FAIL ptt_expiry_time: got %0d clocks expected %0d..%0d",
                     n, CLK_PER_MS, 3 * CLK_PER_MS + 8);
        end
        testsRun++;
        if (status !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ptt_expiry_status: got %b expected 1", status);
        end
        expQ.push_back({8'h01, 32'h06000000});
        sendFrame(32'h06000000);
        testsRun++;
        if (status !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL get_status_clear: got %b expected 0", status);
        end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (rxQ.size() > 0) ? rxQ.pop_front() : 'x;
            testsRun++;
            if (got !== exp) begin
                testsFailed++; $display("[TB] FAIL ptt_echo: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_ptt_refresh();
        int low0;
        logic [39:0] exp, got;
        expQ.push_back({8'h00, 32'h020001F4});
        sendFrame(32'h020001F4);
        low0 = paLowCycles;
        watchPa = 1'b1;
        for (int k = 0; k < 8; k++) begin
            repeat (250 * CLK_PER_MS - 600) @(negedge clock);
            expQ.push_back({8'h00, 32'h020001F4});
            sendFrame(32'h020001F4);
        end
        watchPa = 1'b0;
        testsRun++;
        if (paLowCycles != low0) begin
            testsFailed++; $display("[TB] FAIL ptt_refresh_glitch: got %0d low clocks expected 0", paLowCycles - low0);
        end
        testsRun++;
        if (pa_bias !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ptt_refresh_hold: got %b expected 1", pa_bias);
        end
        expQ.push_back({8'h00, 32'h03000000});
        sendFrame(32'h03000000);
        testsRun++;
        if ({pa_bias, status} !== 2'b00) begin
            testsFailed++; $display("[TB] FAIL ptt_disable: got %b expected 00", {pa_bias, status});
        end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (rxQ.size() > 0) ? rxQ.pop_front() : 'x;
            testsRun++;
            if (got !== exp) begin
                testsFailed++; $display("[TB] FAIL refresh_echo: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_tuning();
        logic [39:0] exp, got;
        expQ.push_back({8'h00, 32'h01800000}); sendFrame(32'h01800000);
        expQ.push_back({8'h00, 32'h04000000}); sendFrame(32'h04000000);
        testsRun++;
        if (tuning !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL tune_ignored: got %b expected 0", tuning);
        end
        expQ.push_back({8'h00, 32'h01400000}); sendFrame(32'h01400000);
        expQ.push_back({8'h00, 32'h04000000}); sendFrame(32'h04000000);
        testsRun++;
        if (tuning !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL tune_start: got %b expected 1", tuning);
        end
        tune_done = 1'b1;
        @(negedge clock);
        tune_done = 1'b0;
        repeat (2) @(negedge clock);
        testsRun++;
        if ({tuning, status} !== 2'b01) begin
            testsFailed++; $display("[TB] FAIL tune_done: got %b expected 01", {tuning, status});
        end
        expQ.push_back({8'h01, 32'h06000000}); sendFrame(32'h06000000);
        expQ.push_back({8'h00, 32'h04000000}); sendFrame(32'h04000000);
        expQ.push_back({8'h00, 32'h05000000}); sendFrame(32'h05000000);
        testsRun++;
        if ({tuning, status} !== 2'b00) begin
            testsFailed++; $display("[TB] FAIL tune_abort: got %b expected 00", {tuning, status});
        end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (rxQ.size() > 0) ? rxQ.pop_front() : 'x;
            testsRun++;
            if (got !== exp) begin
                testsFailed++; $display("[TB] FAIL tuning_echo: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_framing();
        logic [7:0] d;
        int fv0;
        logic [39:0] exp, got;
        sendOctet(8'hAB, 5, d);
        expQ.push_back({8'h00, 32'h01C00ABC}); sendFrame(32'h01C00ABC);
        testsRun++;
        if (freq_word !== 22'h000ABC) begin
            testsFailed++; $display("[TB] FAIL runt_discard: got %h expected 000abc", freq_word);
        end
        sendOctet(8'h01, 8, d);
        sendOctet(8'hFF, 8, d);
        repeat (GAP + 50) @(negedge clock);
        expQ.push_back({8'h00, 32'h01400123}); sendFrame(32'h01400123);
        testsRun++;
        if ({filter_en, tuner_en, freq_word} !== {1'b0, 1'b1, 22'h000123}) begin
            testsFailed++;
            $display("[TB] FAIL gap_timeout: got %h expected %h",
                     {filter_en, tuner_en, freq_word}, {1'b0, 1'b1, 22'h000123});
        end
        fv0 = fvPulses;
        sendOctet(8'h01, 8, d);
        sendOctet(8'h00, 8, d);
        sendOctet(8'h07, 8, d);
        ss = 1'b0;
        repeat (HALF) @(negedge clock);
        apollo_reset_n = 1'b0;
        repeat (3) @(negedge clock);
        testsRun++;
        if ({miso, freq_word, tuner_en} !== {1'b1, 22'd0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL apollo_reset_state: got %h expected %h",
                     {miso, freq_word, tuner_en}, {1'b1, 22'd0, 1'b0});
        end
        ss = 1'b1;
        apollo_reset_n = 1'b1;
        sendOctet(8'h77, 8, d);
        sendOctet(8'h00, 8, d);
        repeat (GAP + 50) @(negedge clock);
        testsRun++;
        if (fvPulses != fv0 || freq_word !== 22'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_no_exec: got %0d pulses word %h expected 0 pulses word 0",
                     fvPulses - fv0, freq_word);
        end
        testsRun++;
        if (status !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL reready: got %b expected 1", status);
        end
        expQ.push_back({8'h01, 32'h06000000}); sendFrame(32'h06000000);
        expQ.push_back({8'h00, 32'h07000000}); sendFrame(32'h07000000);
        expQ.push_back({8'h01, 32'h00000000}); sendFrame(32'h00000000);
        expQ.push_back({8'h00, 32'h00000000}); sendFrame(32'h00000000);
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (rxQ.size() > 0) ? rxQ.pop_front() : 'x;
            testsRun++;
            if (got !== exp) begin
                testsFailed++; $display("[TB] FAIL framing_echo: got %h expected %h", got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_freq();
        test_ptt_watchdog();
        test_ptt_refresh();
        test_tuning();
        test_framing();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
